// File: rtl/arm_ctrl_pkg.sv
// Shared encodings, decoded-control bundle and condition evaluation for the
// pipelined ARM control unit.
package arm_ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_NORM = 2'b00;
    localparam logic [1:0] REGSRC_BR   = 2'b01;
    localparam logic [1:0] REGSRC_STR  = 2'b10;

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic [1:0] flag_w;
        logic [3:0] cond;
    } de_ctrl_t;

    // flags = {N,Z,C,V}; the reserved 1111 code never executes
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = ~z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = ~c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = ~n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = ~v;
            COND_HI: cond_holds = c & ~z;
            COND_LS: cond_holds = ~c | z;
            COND_GE: cond_holds = (n == v);
            COND_LT: cond_holds = (n != v);
            COND_GT: cond_holds = ~z & (n == v);
            COND_LE: cond_holds = z | (n != v);
            COND_AL: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV register, condition check and gating of
// the side-effecting controls of the instruction in Execute.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [1:0] i_flag_w,
    input  logic [3:0] i_alu_flags,
    input  logic       i_pcs,
    input  logic       i_regw,
    input  logic       i_memw,
    input  logic       i_branch,
    output logic       o_pcs,
    output logic       o_regw,
    output logic       o_memw,
    output logic       o_branch_taken
);

    logic [3:0] r_flags;
    logic       w_cond_ex;
    logic [1:0] w_flag_we;

    assign w_cond_ex      = cond_holds(i_cond, r_flags);
    assign w_flag_we      = i_flag_w & {2{w_cond_ex}};
    assign o_pcs          = i_pcs    & w_cond_ex;
    assign o_regw         = i_regw   & w_cond_ex;
    assign o_memw         = i_memw   & w_cond_ex;
    assign o_branch_taken = i_branch & w_cond_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            if (w_flag_we[1]) r_flags[3:2] <= i_alu_flags[3:2];
            if (w_flag_we[0]) r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

endmodule

// File: rtl/arm_pipe_controller.sv
// Pipelined ARM control unit: Decode-stage decoder plus D->E, E->M and M->W
// control registers around the Execute-stage condition unit.
module arm_pipe_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemtoRegE,
    output logic        MemWriteM,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op;
    logic       w_imm, w_s, w_unused;
    de_ctrl_t   w_ctrl_d, r_de;
    logic       w_pcs_e, w_regw_e, w_memw_e;
    logic       r_pcs_m, r_regw_m, r_memw_m, r_memtoreg_m;
    logic       r_pcs_w, r_regw_w, r_memtoreg_w;

    // InstrD holds Instr[31:12], so every field sits 12 bits lower
    assign w_cond   = InstrD[19:16];
    assign w_op     = InstrD[15:14];
    assign w_imm    = InstrD[13];
    assign w_cmd    = InstrD[12:9];
    assign w_s      = InstrD[8];
    assign w_rd     = InstrD[3:0];
    assign w_unused = ^InstrD[7:4];

    always_comb begin
        w_ctrl_d      = '0;
        w_ctrl_d.cond = w_cond;
        RegSrcD       = REGSRC_NORM;
        ImmSrcD       = IMM_DP;
        case (w_op)
            OP_DP: begin
                w_ctrl_d.regw    = 1'b1;
                w_ctrl_d.alu_src = w_imm;
                case (w_cmd)
                    CMD_ADD: begin
                        w_ctrl_d.alu_ctrl = ALU_ADD;
                        w_ctrl_d.flag_w   = w_s ? 2'b11 : 2'b00;
                    end
                    CMD_SUB: begin
                        w_ctrl_d.alu_ctrl = ALU_SUB;
                        w_ctrl_d.flag_w   = w_s ? 2'b11 : 2'b00;
                    end
                    CMD_AND: begin
                        w_ctrl_d.alu_ctrl = ALU_AND;
                        w_ctrl_d.flag_w   = w_s ? 2'b10 : 2'b00;
                    end
                    CMD_ORR: begin
                        w_ctrl_d.alu_ctrl = ALU_OR;
                        w_ctrl_d.flag_w   = w_s ? 2'b10 : 2'b00;
                    end
                    CMD_CMP: begin
                        w_ctrl_d.alu_ctrl = ALU_SUB;
                        w_ctrl_d.regw     = 1'b0;
                        w_ctrl_d.flag_w   = 2'b11;
                    end
                    default: begin
                        w_ctrl_d.regw    = 1'b0;
                        w_ctrl_d.alu_src = 1'b0;
                    end
                endcase
            end
            OP_MEM: begin
                w_ctrl_d.alu_src  = 1'b1;
                w_ctrl_d.alu_ctrl = ALU_ADD;
                ImmSrcD           = IMM_MEM;
                if (w_s) begin
                    w_ctrl_d.regw     = 1'b1;
                    w_ctrl_d.memtoreg = 1'b1;
                end else begin
                    w_ctrl_d.memw = 1'b1;
                    RegSrcD       = REGSRC_STR;
                end
            end
            OP_BR: begin
                w_ctrl_d.branch   = 1'b1;
                w_ctrl_d.alu_src  = 1'b1;
                w_ctrl_d.alu_ctrl = ALU_ADD;
                ImmSrcD           = IMM_BR;
                RegSrcD           = REGSRC_BR;
            end
            default: ;
        endcase
        w_ctrl_d.pcs = w_ctrl_d.branch | (w_ctrl_d.regw & (w_rd == 4'hF));
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) r_de <= '0;
        else                 r_de <= w_ctrl_d;
    end

    cond_unit u_cond (
        .clk            (clk),
        .reset          (reset),
        .i_cond         (r_de.cond),
        .i_flag_w       (r_de.flag_w),
        .i_alu_flags    (ALUFlags),
        .i_pcs          (r_de.pcs),
        .i_regw         (r_de.regw),
        .i_memw         (r_de.memw),
        .i_branch       (r_de.branch),
        .o_pcs          (w_pcs_e),
        .o_regw         (w_regw_e),
        .o_memw         (w_memw_e),
        .o_branch_taken (BranchTakenE)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_pcs_m, r_regw_m, r_memw_m, r_memtoreg_m} <= '0;
            {r_pcs_w, r_regw_w, r_memtoreg_w}           <= '0;
        end else begin
            r_pcs_m      <= w_pcs_e;
            r_regw_m     <= w_regw_e;
            r_memw_m     <= w_memw_e;
            r_memtoreg_m <= r_de.memtoreg;
            r_pcs_w      <= r_pcs_m;
            r_regw_w     <= r_regw_m;
            r_memtoreg_w <= r_memtoreg_m;
        end
    end

    assign ALUSrcE      = r_de.alu_src;
    assign ALUControlE  = r_de.alu_ctrl;
    assign MemtoRegE    = r_de.memtoreg;
    assign MemWriteM    = r_memw_m;
    assign RegWriteM    = r_regw_m;
    assign RegWriteW    = r_regw_w;
    assign MemtoRegW    = r_memtoreg_w;
    assign PCSrcW       = r_pcs_w;
    assign PCWrPendingF = w_ctrl_d.pcs | r_de.pcs | r_pcs_m;

endmodule

// File: tb/tb_arm_pipe_controller.sv
// Directed self-checking bench for arm_pipe_controller: a decode/latency
// vector table followed by hand-written flag, flush and reset sequences.
module tb_arm_pipe_controller;

    logic        clk = 1'b0;
    logic        reset, FlushE;
    logic [19:0] InstrD;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrcD, ImmSrcD;
    logic        ALUSrcE, BranchTakenE, MemtoRegE, MemWriteM, RegWriteM;
    logic        RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;
    logic [2:0]  ALUControlE;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [19:0] IDLE = 20'hEC000;

    arm_pipe_controller dut (
        .clk          (clk),
        .reset        (reset),
        .InstrD       (InstrD),
        .ALUFlags     (ALUFlags),
        .FlushE       (FlushE),
        .RegSrcD      (RegSrcD),
        .ImmSrcD      (ImmSrcD),
        .ALUSrcE      (ALUSrcE),
        .ALUControlE  (ALUControlE),
        .BranchTakenE (BranchTakenE),
        .MemtoRegE    (MemtoRegE),
        .MemWriteM    (MemWriteM),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .PCSrcW       (PCSrcW),
        .PCWrPendingF (PCWrPendingF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] instr;
        logic [1:0]  regsrc;
        logic [1:0]  immsrc;
        logic        pcs;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic        memtoreg;
        logic        regw;
        logic        memw;
    } vec_t;

    localparam int unsigned NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // instr, regsrc, immsrc, pcs, alusrc, aluctrl, memtoreg, regw, memw
        vecs[0]  = '{20'hE0821, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0}; // ADD
        vecs[1]  = '{20'hE2821, 2'b00, 2'b00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0}; // ADD imm
        vecs[2]  = '{20'hE0021, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0}; // AND
        vecs[3]  = '{20'hE1821, 2'b00, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0}; // ORR
        vecs[4]  = '{20'hE0421, 2'b00, 2'b00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0}; // SUB
        vecs[5]  = '{20'hE1541, 2'b00, 2'b00, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0}; // CMP
        vecs[6]  = '{20'hE58D0, 2'b10, 2'b01, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1}; // STR
        vecs[7]  = '{20'hE59E0, 2'b00, 2'b01, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0}; // LDR
        vecs[8]  = '{20'hEA000, 2'b01, 2'b10, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0}; // B
        vecs[9]  = '{20'hE082F, 2'b00, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0}; // ADD R15
        vecs[10] = '{20'hEC000, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0}; // op 11
        vecs[11] = '{20'hE0221, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0}; // EOR

        reset = 1'b1; FlushE = 1'b0; InstrD = IDLE; ALUFlags = 4'b0000;
        tick(); tick();
        chk("reset_outs", {8'h0, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, MemWriteM,
                           RegWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF}, 20'h0);
        chk("reset_flags", {16'h0, dut.u_cond.r_flags}, 20'h0);
        reset = 1'b0;

        // Table: D outputs now, E at +1, M at +2, W at +3
        for (int unsigned i = 0; i < NV + 3; i++) begin
            tick();
            if (i >= 1 && i - 1 < NV) begin
                chk("tbl_ALUSrcE",     {19'h0, ALUSrcE},     {19'h0, vecs[i-1].alusrc});
                chk("tbl_ALUControlE", {17'h0, ALUControlE}, {17'h0, vecs[i-1].aluctrl});
                chk("tbl_MemtoRegE",   {19'h0, MemtoRegE},   {19'h0, vecs[i-1].memtoreg});
            end
            if (i >= 2 && i - 2 < NV) begin
                chk("tbl_RegWriteM", {19'h0, RegWriteM}, {19'h0, vecs[i-2].regw});
                chk("tbl_MemWriteM", {19'h0, MemWriteM}, {19'h0, vecs[i-2].memw});
            end
            if (i >= 3) begin
                chk("tbl_RegWriteW", {19'h0, RegWriteW}, {19'h0, vecs[i-3].regw});
                chk("tbl_MemtoRegW", {19'h0, MemtoRegW}, {19'h0, vecs[i-3].memtoreg});
                chk("tbl_PCSrcW",    {19'h0, PCSrcW},    {19'h0, vecs[i-3].pcs});
            end
            InstrD = (i < NV) ? vecs[i].instr : IDLE;
            #1;
            if (i < NV) begin
                logic exp_pcw;
                exp_pcw = vecs[i].pcs | (i >= 1 && vecs[i-1].pcs) | (i >= 2 && vecs[i-2].pcs);
                chk("tbl_RegSrcD",      {18'h0, RegSrcD},      {18'h0, vecs[i].regsrc});
                chk("tbl_ImmSrcD",      {18'h0, ImmSrcD},      {18'h0, vecs[i].immsrc});
                chk("tbl_PCWrPendingF", {19'h0, PCWrPendingF}, {19'h0, exp_pcw});
            end
        end

        // SUBS sets Z, following BEQ sees it without a bypass
        tick(); InstrD = 20'hE0521; ALUFlags = 4'b0110;
        tick(); InstrD = 20'h0A000;
        tick(); InstrD = IDLE;
        chk("beq_taken", {19'h0, BranchTakenE}, 20'h1);
        chk("subs_flags", {16'h0, dut.u_cond.r_flags}, 20'h6);
        tick();
        chk("subs_RegWriteW", {19'h0, RegWriteW}, 20'h1);
        tick();
        chk("beq_PCSrcW", {19'h0, PCSrcW}, 20'h1);

        // NE-conditioned ADDS while Z=1 must not commit anything
        tick(); InstrD = 20'h10921; ALUFlags = 4'b1001;
        tick(); InstrD = 20'h00821;
        tick(); InstrD = IDLE;
        chk("ne_RegWriteM", {19'h0, RegWriteM}, 20'h0);
        chk("ne_flags_kept", {16'h0, dut.u_cond.r_flags}, 20'h6);
        tick();
        chk("ne_RegWriteW", {19'h0, RegWriteW}, 20'h0);
        chk("eq_RegWriteM", {19'h0, RegWriteM}, 20'h1);

        // FlushE on an R15 write while SUBS in E still writes flags
        tick(); InstrD = 20'hE0521;
        tick(); InstrD = 20'hE082F; FlushE = 1'b1;
        #1;
        chk("flush_PCWr_D", {19'h0, PCWrPendingF}, 20'h1);
        tick(); InstrD = IDLE; FlushE = 1'b0;
        chk("flush_flags", {16'h0, dut.u_cond.r_flags}, 20'h9);
        chk("flush_subs_RegWriteM", {19'h0, RegWriteM}, 20'h1);
        chk("flush_E_ctrls", {12'h0, ALUSrcE, ALUControlE, MemtoRegE, BranchTakenE, 2'b00}, 20'h0);
        #1;
        chk("flush_PCWr_E", {19'h0, PCWrPendingF}, 20'h0);
        tick();
        chk("flush_RegWriteM", {19'h0, RegWriteM}, 20'h0);
        chk("flush_PCSrcW_a", {19'h0, PCSrcW}, 20'h0);
        tick();
        chk("flush_PCSrcW_b", {19'h0, PCSrcW}, 20'h0);
        chk("flush_RegWriteW", {19'h0, RegWriteW}, 20'h0);

        // Reset with an LDR in M squashes it and clears the flags
        ALUFlags = 4'b0000;
        tick(); InstrD = 20'hE59E0;
        tick(); InstrD = IDLE;
        tick();
        chk("ldr_RegWriteM", {19'h0, RegWriteM}, 20'h1);
        reset = 1'b1; FlushE = 1'b1;
        tick();
        chk("rst_MemtoRegW", {19'h0, MemtoRegW}, 20'h0);
        chk("rst_RegWriteW", {19'h0, RegWriteW}, 20'h0);
        chk("rst_flags", {16'h0, dut.u_cond.r_flags}, 20'h0);
        reset = 1'b0; FlushE = 1'b0; InstrD = 20'h0A000;
        tick();
        chk("rst_beq_not_taken", {19'h0, BranchTakenE}, 20'h0);
        InstrD = 20'h1A000;
        tick();
        chk("rst_bne_taken", {19'h0, BranchTakenE}, 20'h1);
        InstrD = IDLE;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
